key_lock_pipe: RTL and testbench

- Parametrised, registered logic-locking stage: a DATA_W-bit valid/ready data path passes through per-bit XOR/XNOR key gates into a one-deep output register.
- Key bits arrive serially over a valid/ready load port, are collected in a shadow register and committed atomically to the active key.
- Data passes unmodified only when the committed key equals XNOR_MASK. Any other key scrambles the data deterministically.
- Sits between the locked core outputs and downstream logic; the successor to fixed-width combinational key gates.

---
 rtl/key_lock_pkg.sv | 16 +
 rtl/key_shift_loader.sv | 127 ++++++++++++
 rtl/key_lock_pipe.sv | 86 ++++++++
 tb/tb_key_lock_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_lock_pkg.sv
// rtl/key_lock_pkg.sv - shared FSM state type and per-bit key gate for the key lock stage
package key_lock_pkg;

    // Serial key loader states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } key_fsm_e;

    // One key gate: XNOR when the mask bit is set, XOR otherwise
    function automatic logic key_gate(input logic data, input logic key, input logic mask);
        return mask ? ~(data ^ key) : (data ^ key);
    endfunction

endpackage

// File: rtl/key_shift_loader.sv
// rtl/key_shift_loader.sv - serial key shadow register, bit counter and commit FSM (KEY_PARITY_EN adds a trailing parity bit)
module key_shift_loader
    import key_lock_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_key_valid,
    output logic              o_key_ready,
    input  logic              i_key_bit,
    input  logic              i_key_abort,
    output logic              o_key_loaded,
    output logic              o_key_err,
    output logic [DATA_W-1:0] o_shadow
);

`ifdef KEY_PARITY_EN
    localparam int LOAD_BITS = DATA_W + 1;
`else
    localparam int LOAD_BITS = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BITS - 1);

    key_fsm_e          r_state;
    key_fsm_e          w_state_nxt;
    logic [DATA_W-1:0] r_shadow;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_clear;
    logic              w_shift;
    logic              w_par_ok;

`ifdef KEY_PARITY_EN
    logic r_par;
    logic r_err;

    // The final accepted bit is the parity bit and never enters the shadow
    assign w_shift   = w_accept && (r_cnt != LAST_CNT);
    assign w_par_ok  = ((^r_shadow) == r_par);
    assign o_key_err = r_err;

    // Parity bit capture and sticky error flag, cleared by the next bit or an abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_par <= 1'b0;
            if (!w_par_ok) begin
                r_err <= 1'b1;
            end
        end else if (i_key_abort) begin
            r_par <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
            if (r_cnt == LAST_CNT) begin
                r_par <= i_key_bit;
            end
        end
    end
`else
    assign w_shift   = w_accept;
    assign w_par_ok  = 1'b1;
    assign o_key_err = 1'b0;
`endif

    assign o_shadow = r_shadow;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, port handshake and commit pulse
    always_comb begin
        w_state_nxt  = r_state;
        o_key_ready  = 1'b0;
        o_key_loaded = 1'b0;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE, LOAD: begin
                o_key_ready = 1'b1;
                if (i_key_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (i_key_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_cnt == LAST_CNT) ? COMMIT : LOAD;
                end
            end
            COMMIT: begin
                o_key_loaded = w_par_ok;
                w_clear      = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow shifts right with new bits entering at the MSB, so LSB-first ends aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (w_clear) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_shift) begin
                r_shadow <= {i_key_bit, r_shadow[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/key_lock_pipe.sv
// rtl/key_lock_pipe.sv - key-gated one-deep register stage with serial key load (KEY_PARITY_EN enables key parity)
module key_lock_pipe
    import key_lock_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] XNOR_MASK = '0,
`ifdef KEY_PARITY_EN
    parameter int                CNT_W     = $clog2(DATA_W + 2)
`else
    parameter int                CNT_W     = $clog2(DATA_W + 1)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              key_bit,
    input  logic              key_abort,
    output logic              key_loaded,
    output logic              key_err
);

    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] w_gate;
    logic [DATA_W-1:0] w_shadow;
    logic              w_key_loaded;

    key_shift_loader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_valid  (key_valid),
        .o_key_ready  (key_ready),
        .i_key_bit    (key_bit),
        .i_key_abort  (key_abort),
        .o_key_loaded (w_key_loaded),
        .o_key_err    (key_err),
        .o_shadow     (w_shadow)
    );

    assign key_loaded = w_key_loaded;
    assign in_ready   = !r_out_valid || out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    // Active key is written atomically from the shadow on a successful commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (w_key_loaded) begin
            r_key <= w_shadow;
        end
    end

    // Per-bit key gates ahead of the output register
    always_comb begin
        w_gate = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_gate[i] = key_gate(in_data[i], r_key[i], XNOR_MASK[i]);
        end
    end

    // One-deep output register; data holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gate;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_lock_pipe.sv
// tb/tb_key_lock_pipe.sv - directed bench with reference model for key_lock_pipe (KEY_PARITY_EN adds parity cases)
module tb_key_lock_pipe;

    localparam logic [7:0] MASK = 8'hA5;
`ifdef KEY_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       key_bit = 1'b0;
    logic       key_abort = 1'b0;
    logic       key_loaded;
    logic       key_err;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    key_lock_pipe #(
        .DATA_W    (8),
        .XNOR_MASK (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_bit    (key_bit),
        .key_abort  (key_abort),
        .key_loaded (key_loaded),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: key as an array of collected bits, output as a one-slot buffer
    logic [7:0] m_key = 8'h00;
    logic [7:0] m_acc = 8'h00;
    logic       m_par = 1'b0;
    int         m_n = 0;
    bit         m_commit = 1'b0;
    bit         m_err = 1'b0;
    bit         m_ovalid = 1'b0;
    logic [7:0] m_odata = 8'h00;

    function automatic bit m_par_ok();
        if (NBITS == 8) return 1'b1;
        return ((m_acc[0] + m_acc[1] + m_acc[2] + m_acc[3] + m_acc[4] + m_acc[5] + m_acc[6] + m_acc[7]) % 2) == m_par;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key = 8'h00; m_acc = 8'h00; m_par = 1'b0; m_n = 0;
            m_commit = 1'b0; m_err = 1'b0; m_ovalid = 1'b0; m_odata = 8'h00;
        end else begin
            if (in_valid && (!m_ovalid || out_ready)) begin
                m_odata  = in_data ^ m_key ^ MASK;
                m_ovalid = 1'b1;
            end else if (out_ready) begin
                m_ovalid = 1'b0;
            end
            if (m_commit) begin
                if (m_par_ok()) m_key = m_acc;
                else m_err = 1'b1;
                m_commit = 1'b0; m_acc = 8'h00; m_par = 1'b0; m_n = 0;
            end else if (key_abort) begin
                m_acc = 8'h00; m_par = 1'b0; m_n = 0; m_err = 1'b0;
            end else if (key_valid) begin
                m_err = 1'b0;
                if (m_n < 8) m_acc[m_n] = key_bit;
                else m_par = key_bit;
                m_n++;
                if (m_n == NBITS) m_commit = 1'b1;
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", {7'b0, out_valid}, {7'b0, m_ovalid});
            chk("m_out_data", out_data, m_odata);
            chk("m_in_ready", {7'b0, in_ready}, {7'b0, (!m_ovalid || out_ready)});
            chk("m_key_ready", {7'b0, key_ready}, {7'b0, !m_commit});
            chk("m_key_loaded", {7'b0, key_loaded}, {7'b0, (m_commit && m_par_ok())});
            chk("m_key_err", {7'b0, key_err}, {7'b0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Load an 8-bit key LSB first (plus parity bit when enabled) and check the commit cycle
    task automatic load_key(input logic [7:0] k, input logic par, input logic exp_ok, input logic [7:0] commit_beat);
        logic [7:0] kv;
        kv = k;
        for (int i = 0; i < NBITS; i++) begin
            key_valid = 1'b1;
            key_bit   = (i < 8) ? kv[i] : par;
            tick();
            if (i == 0) chk("key_err_clear", {7'b0, key_err}, 8'h00);
        end
        key_valid = 1'b0;
        chk("commit_loaded", {7'b0, key_loaded}, {7'b0, exp_ok});
        chk("commit_key_ready", {7'b0, key_ready}, 8'h00);
        send_beat(8'h3C);
        chk("commit_edge_beat", out_data, commit_beat);
        chk("loaded_pulse_end", {7'b0, key_loaded}, 8'h00);
    endtask

    initial begin
        #1;
        do_reset();
        chk_en = 1'b1;
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_key_err", {7'b0, key_err}, 8'h00);

        send_beat(8'h3C);
        chk("reset_key_beat", out_data, 8'h99);
        chk("reset_key_valid", {7'b0, out_valid}, 8'h01);

        load_key(8'hA5, 1'b0, 1'b1, 8'h99);
        send_beat(8'h3C);
        chk("unlocked_beat", out_data, 8'h3C);
        tick();

        // Reset mid-load with a beat in the output register
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_bit = i[0];
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {7'b0, out_valid}, 8'h00);
        chk("async_rst_data", out_data, 8'h00);
        chk("async_rst_key_ready", {7'b0, key_ready}, 8'h01);
        key_valid = 1'b0; in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        send_beat(8'h00);
        chk("post_rst_beat", out_data, 8'hA5);

        // Abort a partial load
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            tick();
        end
        key_abort = 1'b1;
        tick();
        key_abort = 1'b0; key_valid = 1'b0;
        send_beat(8'h3C);
        chk("abort_key_kept", out_data, 8'h99);
        load_key(8'hA5, 1'b0, 1'b1, 8'h99);
        send_beat(8'h3C);
        chk("reload_beat", out_data, 8'h3C);
        tick();

        // Backpressure then full-rate stream
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        #1;
        chk("stall_in_ready", {7'b0, in_ready}, 8'h00);
        tick();
        chk("stall_hold", out_data, 8'h11);
        chk("stall_valid", {7'b0, out_valid}, 8'h01);
        out_ready = 1'b1;
        tick();
        chk("stream_b1", out_data, 8'h22);
        in_data = 8'h33;
        tick();
        chk("stream_b2", out_data, 8'h33);
        in_data = 8'h44;
        tick();
        chk("stream_b3", out_data, 8'h44);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {7'b0, out_valid}, 8'h00);

`ifdef KEY_PARITY_EN
        do_reset();
        load_key(8'hA5, 1'b1, 1'b0, 8'h99);
        chk("par_err_set", {7'b0, key_err}, 8'h01);
        send_beat(8'h3C);
        chk("par_still_locked", out_data, 8'h99);
        load_key(8'hA5, 1'b0, 1'b1, 8'h99);
        send_beat(8'h3C);
        chk("par_unlocked", out_data, 8'h3C);
`endif

        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
